// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: branch encodings, default vectors, redirect causes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQZ  = 2'b01;
    localparam logic [1:0] BR_NEZ  = 2'b10;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    typedef enum logic [2:0] {
        CAUSE_NONE,
        CAUSE_EXC,
        CAUSE_ERET,
        CAUSE_BR,
        CAUSE_J,
        CAUSE_JR
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FULL
    } fetch_st_e;

endpackage

// File: rtl/npc_target.sv
// Computes branch/jump/jr/exception/eret targets and picks the highest-priority redirect.
// Latency: purely combinational.
// Backpressure: none; D-stage inputs are only honoured when d_fire is high.
module npc_target
    import fetch_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic              d_fire,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [1:0]        br_d,
    input  logic              zero_d,
    input  logic [15:0]       imm16_d,
    input  logic              jal_d,
    input  logic [25:0]       imm26_d,
    input  logic              jr_d,
    input  logic [ADDR_W-1:0] ra_d,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [2:0]        cause
);

    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic              br_taken;

    // Target arithmetic and priority: exc > eret > taken branch > j/jal > jr.
    always_comb begin
        br_tgt   = pc_d + ADDR_W'(4) + ({{(ADDR_W-16){imm16_d[15]}}, imm16_d} << 2);
        j_tgt    = ADDR_W'({pc_d[ADDR_W-1:ADDR_W-4], imm26_d, 2'b00});
        br_taken = d_fire && (((br_d == BR_EQZ) && zero_d) || ((br_d == BR_NEZ) && !zero_d));

        redirect_valid = 1'b1;
        redirect_pc    = '0;
        cause          = CAUSE_NONE;
        if (exc_req) begin
            redirect_pc = EXC_VEC;
            cause       = CAUSE_EXC;
        end else if (eret_req) begin
            redirect_pc = epc;
            cause       = CAUSE_ERET;
        end else if (br_taken) begin
            redirect_pc = br_tgt;
            cause       = CAUSE_BR;
        end else if (d_fire && jal_d) begin
            redirect_pc = j_tgt;
            cause       = CAUSE_J;
        end else if (d_fire && jr_d) begin
            redirect_pc = ra_d;
            cause       = CAUSE_JR;
        end else begin
            redirect_valid = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: one outstanding imem request, one-entry output buffer, redirect/kill handling.
// Latency: ack in the request cycle gives the instruction on if_* the next cycle, 1 instr/cycle sustained.
// Backpressure: if_ready low holds the buffer and suppresses new requests; in-flight requests always complete.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [ADDR_W-1:0] EXC_VEC    = EXC_VEC_DEF,
    parameter bit                DELAY_SLOT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_fire,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [1:0]        br_d,
    input  logic              zero_d,
    input  logic [15:0]       imm16_d,
    input  logic              jal_d,
    input  logic [25:0]       imm26_d,
    input  logic              jr_d,
    input  logic [ADDR_W-1:0] ra_d,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc8,
    input  logic              if_ready,
    output logic              flush_fd
);

    fetch_st_e         st, st_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic              kill;
    logic [ADDR_W-1:0] kill_addr;
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [2:0]        cause;

    logic              is_ctrl;
    logic              is_exc;
    logic              ds_pend;
    logic              kill_now;
    logic              drop_buf;
    logic              load;

    npc_target #(
        .ADDR_W (ADDR_W),
        .EXC_VEC(EXC_VEC)
    ) u_npc_target (
        .d_fire        (d_fire),
        .pc_d          (pc_d),
        .br_d          (br_d),
        .zero_d        (zero_d),
        .imm16_d       (imm16_d),
        .jal_d         (jal_d),
        .imm26_d       (imm26_d),
        .jr_d          (jr_d),
        .ra_d          (ra_d),
        .exc_req       (exc_req),
        .eret_req      (eret_req),
        .epc           (epc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .cause         (cause)
    );

    assign if_pc8 = if_pc + ADDR_W'(8);

    // Redirect classification, request/buffer control and next state.
    always_comb begin
        is_ctrl  = (cause == CAUSE_BR) || (cause == CAUSE_J) || (cause == CAUSE_JR);
        is_exc   = (cause == CAUSE_EXC) || (cause == CAUSE_ERET);
        // Delay slot not yet requested: let it go out, then continue at the target.
        ds_pend  = DELAY_SLOT && redirect_valid && is_ctrl && (fetch_pc == pc_d + ADDR_W'(4));
        kill_now = redirect_valid && !ds_pend;
        // With a delay slot, a buffered instruction survives only if it is the delay slot itself.
        drop_buf = kill_now && !(DELAY_SLOT && is_ctrl && (if_pc == pc_d + ADDR_W'(4)));
        flush_fd = redirect_valid && (is_exc || !DELAY_SLOT);

        imem_req  = (st == ST_FETCH) || ((st == ST_FULL) && if_ready);
        imem_addr = kill ? kill_addr : fetch_pc;
        if_valid  = (st == ST_FULL) && !drop_buf;
        load      = imem_req && imem_ack && !kill && !kill_now;

        st_nxt = st;
        case (st)
            ST_IDLE:  st_nxt = ST_FETCH;
            ST_FETCH: if (load) st_nxt = ST_FULL;
            ST_FULL: begin
                if (load)                     st_nxt = ST_FULL;
                else if (drop_buf || if_ready) st_nxt = ST_FETCH;
            end
            default:  st_nxt = ST_IDLE;
        endcase
    end

    // State, fetch PC, kill/pend bookkeeping and the output buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st        <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            kill      <= 1'b0;
            kill_addr <= RESET_PC;
            pend      <= 1'b0;
            pend_pc   <= RESET_PC;
            if_instr  <= '0;
            if_pc     <= RESET_PC;
        end else begin
            st <= st_nxt;

            if (load) begin
                if_instr <= imem_rdata;
                if_pc    <= imem_addr;
            end

            // A killed request still owns the bus until its ack; the address stays frozen.
            if (kill) begin
                if (imem_ack) kill <= 1'b0;
            end else if (kill_now && imem_req && !imem_ack) begin
                kill      <= 1'b1;
                kill_addr <= imem_addr;
            end

            if (kill_now) begin
                fetch_pc <= redirect_pc;
                pend     <= 1'b0;
            end else if (ds_pend) begin
                if (load) begin
                    fetch_pc <= redirect_pc;
                    pend     <= 1'b0;
                end else begin
                    pend    <= 1'b1;
                    pend_pc <= redirect_pc;
                end
            end else if (load) begin
                fetch_pc <= pend ? pend_pc : fetch_pc + ADDR_W'(4);
                pend     <= 1'b0;
            end
        end
    end

endmodule
